// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch (I) and data (D) stages
//
// Shares one single-ported memory between the fetch stage and the mem/wb data
// stage. The winning request is registered onto the m_* port and held until
// m_ack. Read data then returns to the winner as a one-cycle rvalid pulse. A
// BUSY phase that lasts TIMEOUT cycles without m_ack is aborted, and err pulses
// for one cycle.
//
// Optional feature macro: MEM_PORT_ARB_RR_EN. When it is defined, contested
// grants alternate between I and D. When it is undefined, D always has priority
// over I.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   i_req/i_addr                fetch read request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata      fetch grant, completion pulse, read data
//   d_req/d_we/d_addr/d_wdata   data request (d_we=0 is a load)
//   d_gnt/d_rvalid/d_rdata      data grant, completion pulse, load data
//   m_req/m_we/m_addr/m_wdata   registered memory request (held until m_ack)
//   m_ack/m_rdata               memory completion, read data on the same cycle
//   stall                       a requester is waiting this cycle
//   err                         timeout abort pulse
module mem_port_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  // Abort fires in the BUSY cycle whose count reaches TIMEOUT-1, so the
  // transaction gets exactly TIMEOUT BUSY cycles in which m_ack can arrive.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             pick_d;
  logic             timeout_hit;

`ifdef MEM_PORT_ARB_RR_EN
  // Last-winner flop: 1 = D won the previous grant. It resets to I, so the
  // first contested pick goes to D.
  logic last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_d <= 1'b0;
    else if (d_gnt) last_d <= 1'b1;
    else if (i_gnt) last_d <= 1'b0;
  end

  assign pick_d = d_req & (~i_req | ~last_d);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          d_gnt     = 1'b1;
          state_nxt = BUSY_D;
        end else if (i_req) begin
          i_gnt     = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        // An m_ack that arrives in the final counted cycle still completes normally.
        if (m_ack) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall = (i_req & ~i_gnt) | (d_req & ~d_gnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_req    <= 1'b0;
      m_we     <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      err      <= 1'b0;
      cnt      <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      err      <= 1'b0;
      if (state == IDLE) begin
        if (d_gnt) begin
          m_req   <= 1'b1;
          m_we    <= d_we;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          cnt     <= '0;
        end else if (i_gnt) begin
          m_req  <= 1'b1;
          m_we   <= '0;
          m_addr <= i_addr;
          cnt    <= '0;
        end
      end else if (m_ack) begin
        m_req <= 1'b0;
        m_we  <= '0;
        if (state == BUSY_D) begin
          d_rvalid <= 1'b1;
          d_rdata  <= m_rdata;
        end else begin
          i_rvalid <= 1'b1;
          i_rdata  <= m_rdata;
        end
      end else if (timeout_hit) begin
        m_req <= 1'b0;
        m_we  <= '0;
        err   <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
